lcd_host_seq: RTL and testbench
===============================

Name: lcd_host_seq

Overview:
- Command initiator that drives the 6x6 LCD window controller from the host side.
- Holds a 36-byte image buffer and accepts one command request at a time.
- Issues cmd/cmd_valid, streams image bytes on load, and captures the returned 3x3 window into a readable 9-byte buffer.
- Sits between the test/system sequencer and the LCD controller; detects bad commands and output timeouts.

Parameters:
- TIMEOUT, 64, max cycles in CAPTURE before 9 output beats arrive; then error.
- IMG_W, 6, image side length; buffer holds IMG_W*IMG_W bytes.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous active-low reset
- req_valid  in  1  command request
- req_cmd  in  3  0 reflash, 1 load, 2 right, 3 left, 4 up, 5 down
- req_ready  out  1  request accepted this cycle
- img_we  in  1  image buffer write enable
- img_addr  in  6  image write address 0..35
- img_wdata  in  8  image write data
- win_addr  in  4  capture buffer read address 0..8
- win_data  out  8  capture byte, combinational; 0 when win_addr>8
- done  out  1  one-cycle pulse: command finished
- err_badcmd  out  1  sticky until next accepted request
- err_timeout  out  1  sticky until next accepted request
- lcd_cmd  out  3  to controller cmd
- lcd_cmd_valid  out  1  to controller cmd_valid
- lcd_datain  out  8  to controller datain
- lcd_dataout  in  8  from controller dataout
- lcd_output_valid  in  1  from controller output_valid
- lcd_busy  in  1  from controller busy

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; counters 0; capture buffer 0. The image buffer is not cleared.
- All lcd_* and status outputs are registered.
- IDLE:
  - req_ready = req_valid && !lcd_busy, combinational.
  - On acceptance: latch req_cmd; clear err_badcmd and err_timeout.
  - req_cmd 6/7: set err_badcmd, go to DONE; nothing is issued.
  - Otherwise go to ISSUE.
- ISSUE: exactly one cycle with lcd_cmd_valid=1 and lcd_cmd=the latched command.
  - Next state: LOAD if cmd=1, else CAPTURE.
- LOAD: exactly 36 consecutive cycles, the first beginning the cycle after ISSUE.
  - lcd_datain = img[k], k=0..35 in order; no gaps.
  - After k=35, go to CAPTURE.
- CAPTURE:
  - Each cycle with lcd_output_valid=1: write lcd_dataout to win[idx], idx=0..8.
  - After the 9th beat, go to DONE.
  - Beats after 9 are ignored.
  - Beats during ISSUE or LOAD are ignored.
- Timeout: a counter runs from CAPTURE entry. On reaching TIMEOUT with fewer than 9 beats, set err_timeout and go to DONE. Partial capture data is retained.
- DONE: done=1 for one cycle, then IDLE.
- lcd_datain is 0 outside LOAD. lcd_cmd holds its last value.
- Image write port:
  - Writes accepted in any state except LOAD; writes during LOAD are dropped.
  - img_addr>35 is dropped.
- Capture buffer is readable at any time. It is overwritten only by CAPTURE beats.
- Requests while not IDLE: req_ready=0; the request stalls.
- Mid-operation reset aborts immediately. The controller must be reset together with this block.

Optional Feature:
- WIN_CHECK_EN.
- Defined:
  - Track expected window origin row/col; reset 2,2; load sets 2,2.
  - Shifts move the origin by ±1, clamped 0..3.
  - Each captured beat is compared with img[(row+i)*6+(col+j)].
  - Any difference sets output err_mismatch (1 bit, sticky until next accepted request).
- Undefined: port err_mismatch is still present, tied to 0; no origin tracking logic.

Test Plan:
- Load then reflash: write img[n]=n (n=0..35); req load.
  - lcd_cmd_valid for 1 cycle, then datain 0..35 on 36 consecutive cycles.
  - Controller returns 14,15,16,20,21,22,26,27,28; win[0..8] matches; done pulse; no errors.
- Shift clamp: after load, req right twice, then up 3 times.
  - Final window origin row 0, col 3: win = 3,4,5,9,10,11,15,16,17.
  - With WIN_CHECK_EN: err_mismatch=0.
- Bad command: req_cmd=7.
  - req_ready=1, no lcd_cmd_valid, err_badcmd=1, done one cycle later.
  - Next valid request clears err_badcmd.
- Timeout: TIMEOUT=64; controller model emits only 5 output beats after reflash.
  - err_timeout=1 with done at CAPTURE cycle 64; win[0..4] hold data.
- Stall/busy: hold lcd_busy=1 with req_valid=1 -> req_ready=0 and no issue; release busy -> accepted same cycle.
  - img_we during LOAD leaves the buffer unchanged.
- Reset mid-LOAD at k=20: all outputs 0 immediately; image buffer intact.
  - A fresh load streams from k=0.

Source files
------------

// File: rtl/lcd_host_seq.sv
// Host-side command sequencer for the 6x6 LCD window controller.
// Define WIN_CHECK_EN to compare captured windows against the local image.
module lcd_host_seq #(
    parameter int TIMEOUT = 64,
    parameter int IMG_W   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [2:0] req_cmd,
    output logic       req_ready,
    input  logic       img_we,
    input  logic [5:0] img_addr,
    input  logic [7:0] img_wdata,
    input  logic [3:0] win_addr,
    output logic [7:0] win_data,
    output logic       done,
    output logic       err_badcmd,
    output logic       err_timeout,
    output logic       err_mismatch,
    output logic [2:0] lcd_cmd,
    output logic       lcd_cmd_valid,
    output logic [7:0] lcd_datain,
    input  logic [7:0] lcd_dataout,
    input  logic       lcd_output_valid,
    input  logic       lcd_busy
);
    localparam int IMG_N = IMG_W * IMG_W;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_LOAD, S_CAPT, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      cmd_q, cmd_d;
    logic [5:0]      k_q, k_d;
    logic [3:0]      idx_q, idx_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [2:0]      lcd_cmd_q, lcd_cmd_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic [7:0]      datain_q, datain_d;
    logic            done_q, done_d;
    logic            bad_q, bad_d;
    logic            tmo_q, tmo_d;
    logic            beat_we;
    logic [7:0]      img_q [IMG_N];
    logic [7:0]      win_q [9];

    assign req_ready     = (state_q == S_IDLE) && req_valid && !lcd_busy;
    assign win_data      = (win_addr < 4'd9) ? win_q[win_addr] : 8'd0;
    assign done          = done_q;
    assign err_badcmd    = bad_q;
    assign err_timeout   = tmo_q;
    assign lcd_cmd       = lcd_cmd_q;
    assign lcd_cmd_valid = cmd_valid_q;
    assign lcd_datain    = datain_q;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        k_d         = k_q;
        idx_d       = idx_q;
        tcnt_d      = tcnt_q;
        lcd_cmd_d   = lcd_cmd_q;
        cmd_valid_d = 1'b0;
        datain_d    = 8'd0;
        done_d      = 1'b0;
        bad_d       = bad_q;
        tmo_d       = tmo_q;
        beat_we     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_ready) begin
                    cmd_d = req_cmd;
                    bad_d = 1'b0;
                    tmo_d = 1'b0;
                    if (req_cmd > 3'd5) begin
                        bad_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cmd_valid_d = 1'b1;
                        lcd_cmd_d   = req_cmd;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (cmd_q == 3'd1) begin
                    k_d      = 6'd0;
                    datain_d = img_q[0];
                    state_d  = S_LOAD;
                end else begin
                    idx_d   = 4'd0;
                    tcnt_d  = '0;
                    state_d = S_CAPT;
                end
            end
            S_LOAD: begin
                if (k_q == 6'(IMG_N - 1)) begin
                    idx_d   = 4'd0;
                    tcnt_d  = '0;
                    state_d = S_CAPT;
                end else begin
                    k_d      = k_q + 6'd1;
                    datain_d = img_q[k_q + 6'd1];
                end
            end
            S_CAPT: begin
                tcnt_d = tcnt_q + 1'b1;
                if (lcd_output_valid) begin
                    beat_we = 1'b1;
                    idx_d   = idx_q + 4'd1;
                end
                // a ninth beat on the final cycle still counts as success
                if (lcd_output_valid && idx_q == 4'd8) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cmd_q       <= 3'd0;
            k_q         <= 6'd0;
            idx_q       <= 4'd0;
            tcnt_q      <= '0;
            lcd_cmd_q   <= 3'd0;
            cmd_valid_q <= 1'b0;
            datain_q    <= 8'd0;
            done_q      <= 1'b0;
            bad_q       <= 1'b0;
            tmo_q       <= 1'b0;
            for (int i = 0; i < 9; i++) win_q[i] <= 8'd0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            k_q         <= k_d;
            idx_q       <= idx_d;
            tcnt_q      <= tcnt_d;
            lcd_cmd_q   <= lcd_cmd_d;
            cmd_valid_q <= cmd_valid_d;
            datain_q    <= datain_d;
            done_q      <= done_d;
            bad_q       <= bad_d;
            tmo_q       <= tmo_d;
            if (beat_we) win_q[idx_q] <= lcd_dataout;
        end
    end

    // image store survives reset so a reload after an abort needs no rewrite
    always_ff @(posedge clk) begin
        if (img_we && img_addr < 6'(IMG_N) && state_q != S_LOAD)
            img_q[img_addr] <= img_wdata;
    end

`ifdef WIN_CHECK_EN
    logic [1:0] row_q, row_d, col_q, col_d;
    logic       mis_q, mis_d;
    logic [5:0] eidx;
    int         er, ec;

    always_comb begin
        er   = int'(row_q) + int'(idx_q) / 3;
        ec   = int'(col_q) + int'(idx_q) % 3;
        eidx = 6'(er * IMG_W + ec);
    end

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        mis_d = mis_q;
        if (req_ready) mis_d = 1'b0;
        if (state_q == S_ISSUE) begin
            unique case (cmd_q)
                3'd1: begin
                    row_d = 2'd2;
                    col_d = 2'd2;
                end
                3'd2: col_d = (col_q == 2'd3) ? 2'd3 : col_q + 2'd1;
                3'd3: col_d = (col_q == 2'd0) ? 2'd0 : col_q - 2'd1;
                3'd4: row_d = (row_q == 2'd0) ? 2'd0 : row_q - 2'd1;
                3'd5: row_d = (row_q == 2'd3) ? 2'd3 : row_q + 2'd1;
                default: ;
            endcase
        end
        if (beat_we && lcd_dataout != img_q[eidx]) mis_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q <= 2'd2;
            col_q <= 2'd2;
            mis_q <= 1'b0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            mis_q <= mis_d;
        end
    end

    assign err_mismatch = mis_q;
`else
    assign err_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_host_seq.sv
// Randomized bench for lcd_host_seq with an LCD controller model
// and a window reference computed from image/origin arithmetic.
module tb_lcd_host_seq;
    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_ready;
    logic [2:0] req_cmd;
    logic       img_we;
    logic [5:0] img_addr;
    logic [7:0] img_wdata;
    logic [3:0] win_addr;
    logic [7:0] win_data;
    logic       done, err_badcmd, err_timeout, err_mismatch;
    logic [2:0] lcd_cmd;
    logic       lcd_cmd_valid;
    logic [7:0] lcd_datain, lcd_dataout;
    logic       lcd_output_valid, lcd_busy;

    always #5 clk = ~clk;

    lcd_host_seq #(.TIMEOUT(64), .IMG_W(6)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_ready(req_ready),
        .img_we(img_we), .img_addr(img_addr), .img_wdata(img_wdata),
        .win_addr(win_addr), .win_data(win_data),
        .done(done), .err_badcmd(err_badcmd), .err_timeout(err_timeout),
        .err_mismatch(err_mismatch),
        .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid),
        .lcd_datain(lcd_datain), .lcd_dataout(lcd_dataout),
        .lcd_output_valid(lcd_output_valid), .lcd_busy(lcd_busy)
    );

    int total = 0;
    int bad = 0;
    logic [7:0] img_ref [36];
    logic [7:0] ctl_img [36];
    logic [7:0] win_ref [9];
    int row = 2;
    int col = 2;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int wpos(input int s);
        return (row + s / 3) * 6 + col + s % 3;
    endfunction

    task automatic wr(input int a, input logic [7:0] d);
        @(negedge clk);
        img_we = 1'b1;
        img_addr = 6'(a);
        img_wdata = d;
        if (a < 36) img_ref[a] = d;
    endtask

    task automatic load_image(input bit ramp);
        for (int n = 0; n < 36; n++)
            wr(n, ramp ? 8'(n) : 8'($urandom));
        wr(36 + int'($urandom_range(0, 27)), 8'($urandom));
        @(negedge clk);
        img_we = 1'b0;
    endtask

    task automatic check_win(input string tag);
        for (int i = 0; i < 9; i++) begin
            win_addr = 4'(i);
            #1;
            chk(tag, {24'd0, win_data}, {24'd0, win_ref[i]});
        end
        win_addr = 4'(9 + $urandom_range(0, 6));
        #1;
        chk("win_hi", {24'd0, win_data}, 0);
    endtask

    task automatic model_cmd(input logic [2:0] c);
        case (c)
            3'd1: begin row = 2; col = 2; end
            3'd2: col = (col < 3) ? col + 1 : 3;
            3'd3: col = (col > 0) ? col - 1 : 0;
            3'd4: row = (row > 0) ? row - 1 : 0;
            3'd5: row = (row < 3) ? row + 1 : 3;
            default: ;
        endcase
    endtask

    task automatic do_cmd(input logic [2:0] c, input int nb,
                          input int busy, input bit poke);
        int cstart, done_t, exp_t, ncv, derr, sent, nextb, lastb;
        bit isload;
        isload = (c == 3'd1);
        @(negedge clk);
        req_valid = 1'b1;
        req_cmd = c;
        lcd_busy = (busy > 0);
        for (int i = 0; i < busy; i++) begin
            #1;
            chk("stall_ready", {31'd0, req_ready}, 0);
            chk("stall_cv", {31'd0, lcd_cmd_valid}, 0);
            @(negedge clk);
        end
        lcd_busy = 1'b0;
        #1;
        chk("accept", {31'd0, req_ready}, 1);
        model_cmd(c);
        cstart = isload ? 37 : 1;
        done_t = -1;
        ncv = 0;
        derr = 0;
        sent = 0;
        lastb = 0;
        nextb = cstart + int'($urandom_range(0, 2));
        for (int t = 0; t < cstart + 80; t++) begin
            @(negedge clk);
            req_valid = 1'b0;
            lcd_output_valid = 1'b0;
            img_we = 1'b0;
            if (lcd_cmd_valid) ncv++;
            if (t == 0) begin
                chk("cv_t0", {31'd0, lcd_cmd_valid}, 1);
                chk("cmd", {29'd0, lcd_cmd}, {29'd0, c});
                chk("bad_clr", {31'd0, err_badcmd}, 0);
                chk("tmo_clr", {31'd0, err_timeout}, 0);
            end
            if (isload && t >= 1 && t <= 36) begin
                ctl_img[t-1] = lcd_datain;
                if (lcd_datain !== img_ref[t-1]) derr++;
            end else if (lcd_datain !== 8'd0) derr++;
            if (done_t >= 0) begin
                chk("done_pulse", {31'd0, done}, 0);
                break;
            end
            if (done) begin
                done_t = t;
                chk("err_tmo", {31'd0, err_timeout}, {31'd0, nb < 9});
                chk("err_bad", {31'd0, err_badcmd}, 0);
                chk("err_mis", {31'd0, err_mismatch}, 0);
                lcd_output_valid = 1'b1;
                lcd_dataout = 8'hA5;
            end else if (t < cstart) begin
                if (poke && t >= 5 && t <= 30) begin
                    img_we = 1'b1;
                    img_addr = 6'($urandom_range(0, 35));
                    img_wdata = 8'($urandom);
                end
                if ($urandom_range(0, 3) == 0) begin
                    lcd_output_valid = 1'b1;
                    lcd_dataout = 8'hEE;
                end
            end else if (sent < nb && t >= nextb) begin
                lcd_output_valid = 1'b1;
                lcd_dataout = ctl_img[wpos(sent)];
                win_ref[sent] = img_ref[wpos(sent)];
                sent++;
                lastb = t;
                nextb = t + 1 + int'($urandom_range(0, 2));
            end
        end
        lcd_output_valid = 1'b0;
        exp_t = (nb >= 9) ? lastb + 1 : cstart + 64;
        chk("done_t", done_t, exp_t);
        chk("cv_count", ncv, 1);
        chk("datain", derr, 0);
    endtask

    task automatic do_bad(input logic [2:0] c);
        @(negedge clk);
        req_valid = 1'b1;
        req_cmd = c;
        #1;
        chk("bad_ready", {31'd0, req_ready}, 1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bad_cv", {31'd0, lcd_cmd_valid}, 0);
        chk("bad_done", {31'd0, done}, 1);
        chk("bad_flag", {31'd0, err_badcmd}, 1);
        @(negedge clk);
        chk("bad_done2", {31'd0, done}, 0);
        chk("bad_sticky", {31'd0, err_badcmd}, 1);
        chk("bad_cv2", {31'd0, lcd_cmd_valid}, 0);
    endtask

    task automatic chk_zero(input string tag);
        #1;
        chk({tag, "_cmd"}, {29'd0, lcd_cmd}, 0);
        chk({tag, "_cv"}, {31'd0, lcd_cmd_valid}, 0);
        chk({tag, "_din"}, {24'd0, lcd_datain}, 0);
        chk({tag, "_done"}, {31'd0, done}, 0);
        chk({tag, "_err"}, {29'd0, err_badcmd, err_timeout, err_mismatch}, 0);
        chk({tag, "_rdy"}, {31'd0, req_ready}, 0);
    endtask

    task automatic do_abort();
        @(negedge clk);
        req_valid = 1'b1;
        req_cmd = 3'd1;
        #1;
        chk("ab_accept", {31'd0, req_ready}, 1);
        for (int t = 0; t <= 21; t++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        chk("ab_k20", {24'd0, lcd_datain}, {24'd0, img_ref[20]});
        reset = 1'b0;
        chk_zero("abort");
        row = 2;
        col = 2;
        for (int i = 0; i < 9; i++) win_ref[i] = 8'd0;
        check_win("ab_win");
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int c, nb;
        reset = 1'b0;
        req_valid = 1'b0;
        req_cmd = 3'd0;
        img_we = 1'b0;
        img_addr = 6'd0;
        img_wdata = 8'd0;
        win_addr = 4'd0;
        lcd_dataout = 8'd0;
        lcd_output_valid = 1'b0;
        lcd_busy = 1'b0;
        for (int i = 0; i < 9; i++) win_ref[i] = 8'd0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        check_win("rst_win");
        @(negedge clk);
        reset = 1'b1;

        load_image(1'b1);
        do_cmd(3'd1, 9, 0, 1'b0);
        check_win("load_win");
        win_addr = 4'd0; #1; chk("ramp_w0", {24'd0, win_data}, 14);
        win_addr = 4'd8; #1; chk("ramp_w8", {24'd0, win_data}, 28);
        do_cmd(3'd0, 9, 0, 1'b0);
        check_win("reflash_win");

        do_cmd(3'd2, 9, 0, 1'b0);
        do_cmd(3'd2, 9, 0, 1'b0);
        repeat (3) do_cmd(3'd4, 9, 0, 1'b0);
        check_win("clamp_win");
        win_addr = 4'd0; #1; chk("clamp_w0", {24'd0, win_data}, 3);
        win_addr = 4'd8; #1; chk("clamp_w8", {24'd0, win_data}, 17);

        do_bad(3'd7);
        do_bad(3'd6);
        do_cmd(3'd0, 9, 3, 1'b0);
        do_cmd(3'd0, 5, 0, 1'b0);
        check_win("tmo_win");

        load_image(1'b0);
        do_cmd(3'd1, 9, 0, 1'b1);
        check_win("poke_win");

        do_abort();
        do_cmd(3'd1, 9, 0, 1'b0);
        check_win("reload_win");

        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_bad(3'(6 + $urandom_range(0, 1)));
            end else begin
                c = int'($urandom_range(0, 5));
                if (c == 1 && $urandom_range(0, 1) == 1) load_image(1'b0);
                nb = ($urandom_range(0, 5) == 0) ? 5 + int'($urandom_range(0, 3)) : 9;
                do_cmd(3'(c), nb, int'($urandom_range(0, 2)), c == 1);
            end
            check_win("rand_win");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
